req_arbiter: RTL

Eight-requester arbiter that shares a single downstream resource (a bus, or a functional unit such as the 8-to-3 priority encoder datapath) between up to eight clients. Priority follows the team's established encoder convention: bit 7 is highest and bit 0 is lowest. Once granted, ownership is held until the owner signals `done`, withdraws its request, or exceeds a hold-time limit. An optional round-robin mode rotates priority after each grant so that no requester is starved.

---
 rtl/req_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/req_arbiter.sv
// Eight-requester arbiter with hold-time limit; registered one-hot grant.
// Define ROUND_ROBIN_EN to rotate priority after each grant (default: fixed, bit 7 highest).
module req_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_grant, w_grant_nxt;
  logic [2:0] r_grant_id, w_grant_id_nxt;
  logic       r_grant_valid, w_grant_valid_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] w_win;

`ifdef ROUND_ROBIN_EN
  logic [2:0] r_last, w_last_nxt;

  // Search last-1, last-2, ... last; the nearest hit below last wins.
  function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] id;
    id = '0;
    for (int d = 8; d >= 1; d--) begin
      if (r[3'(last - 3'(d))]) id = 3'(last - 3'(d));
    end
    return id;
  endfunction

  assign w_win = pick_winner(req, r_last);
`else
  function automatic logic [2:0] pick_winner(input logic [7:0] r);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) id = 3'(i);
    end
    return id;
  endfunction

  assign w_win = pick_winner(req);
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_timeout_nxt     = 1'b0;
    w_cnt_nxt         = r_cnt;
`ifdef ROUND_ROBIN_EN
    w_last_nxt        = r_last;
`endif
    case (r_state)
      S_IDLE: begin
        w_grant_nxt       = 8'h00;
        w_grant_id_nxt    = 3'd0;
        w_grant_valid_nxt = 1'b0;
        w_cnt_nxt         = 8'd0;
        if (|req) begin
          w_grant_nxt       = 8'h01 << w_win;
          w_grant_id_nxt    = w_win;
          w_grant_valid_nxt = 1'b1;
          w_state_nxt       = S_BUSY;
`ifdef ROUND_ROBIN_EN
          w_last_nxt        = w_win;
`endif
        end
      end
      S_BUSY: begin
        if (done || !req[r_grant_id] || (r_cnt == CNT_MAX)) begin
          // A normal release takes precedence, so timeout only fires when nothing else ended the grant.
          w_timeout_nxt     = !done && req[r_grant_id];
          w_grant_nxt       = 8'h00;
          w_grant_id_nxt    = 3'd0;
          w_grant_valid_nxt = 1'b0;
          w_cnt_nxt         = 8'd0;
          w_state_nxt       = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 8'h00;
      r_grant_id    <= 3'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= 8'd0;
`ifdef ROUND_ROBIN_EN
      r_last        <= 3'd0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
`ifdef ROUND_ROBIN_EN
      r_last        <= w_last_nxt;
`endif
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule
